// File: rtl/store_checker.sv
// Self-check monitor on the core's data-memory write bus: arms on start, watches
// stores in RUN and latches a sticky pass/fail verdict with failure capture.
module store_checker #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned PASS_ADDR      = 100,
  parameter int unsigned PASS_DATA      = 25,
  parameter int unsigned SCRATCH_LO     = 96,
  parameter int unsigned SCRATCH_HI     = 96,
  parameter int unsigned MIN_STORES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] data_adr,
  input  logic [WIDTH-1:0] write_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE      = 2'd0;
  localparam logic [1:0] CODE_ILLEGAL   = 2'd1;
  localparam logic [1:0] CODE_PREMATURE = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT   = 2'd3;

  localparam logic [WIDTH-1:0] PASS_ADR_C = WIDTH'(PASS_ADDR);
  localparam logic [WIDTH-1:0] PASS_DAT_C = WIDTH'(PASS_DATA);
  localparam logic [WIDTH-1:0] SCR_LO_C   = WIDTH'(SCRATCH_LO);
  localparam logic [WIDTH-1:0] SCR_HI_C   = WIDTH'(SCRATCH_HI);
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_STORES);
  localparam logic [CNT_W-1:0] TO_LAST_C  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             TO_EN_C    = (TIMEOUT_CYCLES != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [1:0]       code_q, code_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             pass_q, fail_q, done_q;

  logic pass_hit, scratch_hit, timeout_hit;

  // Store classification; the pass rule outranks the scratch window on data match.
  assign pass_hit    = mem_write && (data_adr == PASS_ADR_C) && (write_data == PASS_DAT_C);
  assign scratch_hit = mem_write && (data_adr >= SCR_LO_C) && (data_adr <= SCR_HI_C);
  assign timeout_hit = TO_EN_C && (cycle_cnt_q == TO_LAST_C);

  // Next-state and capture logic.
  always_comb begin
    state_d     = state_q;
    store_cnt_d = store_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    code_d      = code_q;
    adr_d       = adr_q;
    data_d      = data_q;

    if (start) begin
      state_d     = S_RUN;
      store_cnt_d = '0;
      cycle_cnt_d = '0;
      code_d      = CODE_NONE;
      adr_d       = '0;
      data_d      = '0;
    end else if (state_q == S_RUN) begin
      if (pass_hit) begin
        if (store_cnt_q >= MIN_C) begin
          state_d = S_PASS;
        end else begin
          state_d = S_FAIL;
          code_d  = CODE_PREMATURE;
          adr_d   = data_adr;
          data_d  = write_data;
        end
      end else if (scratch_hit) begin
        if (store_cnt_q != '1) store_cnt_d = store_cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          state_d = S_FAIL;
          code_d  = CODE_TIMEOUT;
        end
      end else if (mem_write) begin
        state_d = S_FAIL;
        code_d  = CODE_ILLEGAL;
        adr_d   = data_adr;
        data_d  = write_data;
      end else if (timeout_hit) begin
        state_d = S_FAIL;
        code_d  = CODE_TIMEOUT;
      end

      // The resolving cycle is not counted, so a timeout leaves TIMEOUT_CYCLES-1.
      if ((state_d == S_RUN) && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      store_cnt_q <= '0;
      cycle_cnt_q <= '0;
      code_q      <= CODE_NONE;
      adr_q       <= '0;
      data_q      <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_cnt_q <= store_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      code_q      <= code_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      pass_q      <= (state_d == S_PASS);
      fail_q      <= (state_d == S_FAIL);
      done_q      <= (state_d == S_PASS) || (state_d == S_FAIL);
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = code_q;
  assign fail_adr    = adr_q;
  assign fail_data   = data_q;
  assign store_count = store_cnt_q;
  assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_store_checker.sv
// Scoreboard bench for store_checker: three instances (default, MIN_STORES=2,
// TIMEOUT_CYCLES=10) share one stimulus bus; each scenario checks one instance.
module tb_store_checker;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, mem_write;
  logic [W-1:0] data_adr, write_data;

  logic [2:0]    done_w, pass_w, fail_w;
  logic [1:0]    code_w [3];
  logic [W-1:0]  adr_w  [3];
  logic [W-1:0]  dat_w  [3];
  logic [CW-1:0] sc_w   [3];
  logic [CW-1:0] cc_w   [3];

  store_checker u_dut (
    .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
    .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .fail_code(code_w[0]),
    .fail_adr(adr_w[0]), .fail_data(dat_w[0]), .store_count(sc_w[0]), .cycle_count(cc_w[0])
  );

  store_checker #(.MIN_STORES(2)) u_min (
    .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
    .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .fail_code(code_w[1]),
    .fail_adr(adr_w[1]), .fail_data(dat_w[1]), .store_count(sc_w[1]), .cycle_count(cc_w[1])
  );

  store_checker #(.TIMEOUT_CYCLES(10)) u_to (
    .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
    .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .fail_code(code_w[2]),
    .fail_adr(adr_w[2]), .fail_data(dat_w[2]), .store_count(sc_w[2]), .cycle_count(cc_w[2])
  );

  typedef struct packed {
    logic          done;
    logic          pass;
    logic          fail;
    logic [1:0]    code;
    logic [W-1:0]  adr;
    logic [W-1:0]  data;
    logic [CW-1:0] sc;
    logic [CW-1:0] cc;
  } obs_t;

  obs_t exp_q [$];
  obs_t got_q [$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic obs_t mk(input logic d, input logic p, input logic f, input logic [1:0] c,
                              input logic [W-1:0] a, input logic [W-1:0] dt,
                              input logic [CW-1:0] s, input logic [CW-1:0] cy);
    obs_t o;
    o.done = d; o.pass = p; o.fail = f; o.code = c;
    o.adr = a; o.data = dt; o.sc = s; o.cc = cy;
    return o;
  endfunction

  function automatic obs_t sample(input int k);
    obs_t o;
    o.done = done_w[k]; o.pass = pass_w[k]; o.fail = fail_w[k]; o.code = code_w[k];
    o.adr = adr_w[k]; o.data = dat_w[k]; o.sc = sc_w[k]; o.cc = cc_w[k];
    return o;
  endfunction

  // Drive one cycle of bus activity; optionally queue an expectation and the observed result.
  task automatic step(input int k, input logic s, input logic mw, input logic [W-1:0] a,
                      input logic [W-1:0] d, input logic chk, input obs_t e);
    start = s; mem_write = mw; data_adr = a; write_data = d;
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (chk) got_q.push_back(sample(k));
    start = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    obs_t e, o;
    int n = 0;
    reset = 1'b1;
    idle(0, 1);
    step(0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
    step(0, 1'b1, 1'b1, 100, 25, 1'b1, '0);
    step(2, 1'b1, 1'b1, 104, 3, 1'b1, '0);
    reset = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = got_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h expected %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_pass();
    obs_t e, o;
    int n = 0;
    step(0, 1'b1, 1'b0, '0, '0, 1'b1, '0);
    idle(0, 2);
    step(0, 1'b0, 1'b1, 96, 7, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, 3));
    idle(0, 2);
    step(0, 1'b0, 1'b1, 100, 25, 1'b1, mk(1, 1, 0, 0, 0, 0, 1, 5));
    step(0, 1'b0, 1'b1, 104, 3, 1'b1, mk(1, 1, 0, 0, 0, 0, 1, 5));
    step(0, 1'b0, 1'b0, '0, '0, 1'b1, mk(1, 1, 0, 0, 0, 0, 1, 5));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = got_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL pass[%0d]: got %h expected %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    obs_t e, o;
    int n = 0;
    step(0, 1'b1, 1'b0, '0, '0, 1'b1, '0);
    step(0, 1'b0, 1'b1, 104, 3, 1'b1, mk(1, 0, 1, 1, 104, 3, 0, 0));
    step(0, 1'b0, 1'b1, 100, 25, 1'b1, mk(1, 0, 1, 1, 104, 3, 0, 0));
    step(0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(0, 1'b0, 1'b1, 100, 24, 1'b1, mk(1, 0, 1, 1, 100, 24, 0, 0));
    step(0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(0, 1);
    step(0, 1'b0, 1'b1, 97, 1, 1'b1, mk(1, 0, 1, 1, 97, 1, 0, 1));
    step(0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(0, 1'b0, 1'b1, 95, 2, 1'b1, mk(1, 0, 1, 1, 95, 2, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = got_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got %h expected %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_min_stores();
    obs_t e, o;
    int n = 0;
    step(1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1, 1'b0, 1'b1, 96, 1, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, 1));
    step(1, 1'b0, 1'b1, 100, 25, 1'b1, mk(1, 0, 1, 2, 100, 25, 1, 1));
    step(1, 1'b1, 1'b0, '0, '0, 1'b1, '0);
    step(1, 1'b0, 1'b1, 96, 1, 1'b0, '0);
    step(1, 1'b0, 1'b1, 96, 2, 1'b1, mk(0, 0, 0, 0, 0, 0, 2, 2));
    step(1, 1'b0, 1'b1, 100, 25, 1'b1, mk(1, 1, 0, 0, 0, 0, 2, 2));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = got_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL min_stores[%0d]: got %h expected %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    int n = 0;
    step(2, 1'b1, 1'b0, '0, '0, 1'b1, '0);
    idle(2, 8);
    step(2, 1'b0, 1'b0, '0, '0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 9));
    step(2, 1'b0, 1'b0, '0, '0, 1'b1, mk(1, 0, 1, 3, 0, 0, 0, 9));
    idle(2, 2);
    step(2, 1'b0, 1'b1, 96, 4, 1'b1, mk(1, 0, 1, 3, 0, 0, 0, 9));
    step(2, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(2, 9);
    step(2, 1'b0, 1'b1, 100, 25, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 9));
    step(2, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle(2, 9);
    step(2, 1'b0, 1'b1, 96, 5, 1'b1, mk(1, 0, 1, 3, 0, 0, 1, 9));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = got_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got %h expected %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t e, o;
    int n = 0;
    step(0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(0, 1'b0, 1'b1, 96, 1, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, 1));
    reset = 1'b1;
    step(0, 1'b0, 1'b1, 100, 25, 1'b1, '0);
    reset = 1'b0;
    step(0, 1'b0, 1'b1, 100, 25, 1'b1, '0);
    step(0, 1'b0, 1'b1, 104, 1, 1'b1, '0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = got_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_mid_run[%0d]: got %h expected %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int n = 0;
    step(0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(0, 1'b0, 1'b1, 104, 9, 1'b1, mk(1, 0, 1, 1, 104, 9, 0, 0));
    step(0, 1'b1, 1'b1, 104, 1, 1'b1, '0);
    step(0, 1'b0, 1'b1, 100, 25, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0));
    step(0, 1'b1, 1'b1, 100, 25, 1'b1, '0);
    step(0, 1'b0, 1'b1, 100, 25, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = got_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", n, o, e);
      end
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
    test_reset();
    test_pass();
    test_illegal();
    test_min_stores();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
